// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - 16-word data memory behind a req/ack handshake with programmable wait states (optional DMEM_ACCESS_CNT_EN access counters)
module dmem_responder #(
    parameter int DW          = 16,
    parameter int AW          = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic          busy
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [15:0]   rd_cnt,
    output logic [15:0]   wr_cnt
`endif
);

    localparam int DEPTH = 2 ** AW;
    localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          capture, commit;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] addr_l;
    logic          we_l;
    logic [DW-1:0] wdata_l;

    logic [AW-1:0] c_addr;
    logic          c_we;
    logic [DW-1:0] c_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                state_d = req ? ST_RELEASE : ST_IDLE;
            end
            ST_RELEASE: begin
                if (!req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A zero-wait commit happens on the capture edge, so it must use the live inputs.
    assign c_addr  = (state_q == ST_IDLE) ? addr  : addr_l;
    assign c_we    = (state_q == ST_IDLE) ? we    : we_l;
    assign c_wdata = (state_q == ST_IDLE) ? wdata : wdata_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_l  <= '0;
            we_l    <= 1'b0;
            wdata_l <= '0;
            ack     <= 1'b0;
            rdata   <= '0;
            busy    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            ack  <= commit;
            busy <= (state_d != ST_IDLE);
            if (capture) begin
                addr_l  <= addr;
                we_l    <= we;
                wdata_l <= wdata;
            end
            if (commit) begin
                if (c_we) mem[c_addr] <= c_wdata;
                else      rdata       <= mem[c_addr];
            end
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (commit) begin
            if (c_we && wr_cnt_q != 16'hFFFF)  wr_cnt_q <= wr_cnt_q + 16'd1;
            if (!c_we && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target for the 16-bit single-cycle CPU datapath, sitting on the far side of a new request/acknowledge bus.
- Holds 16 x 16-bit words and serves one read or write per transaction.
- Inserts a programmable number of wait states before responding.
- Lets the CPU side be moved to a stalling, handshaked memory interface instead of a zero-latency array.

Parameters:
- DW, 16, data width in bits.
- AW, 4, address width; depth = 2**AW words.
- WAIT_CYCLES, 2, wait states between request capture and response; 0 is legal.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  requester holds high to request a transaction; level-sensitive.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  AW  word address; sampled with req.
- wdata  input  DW  write data; sampled with req.
- ack  output  1  one-cycle response pulse.
- rdata  output  DW  read data; valid while ack is high for a read.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE, wait counter = 0, ack = 0, rdata = 0, busy = 0.
  - All 16 memory words cleared to 0.
  - Latched addr/we/wdata cleared.
- FSM states: IDLE, WAIT, RESP, RELEASE. All outputs are registered.
- IDLE:
  - On an edge with req = 1: latch addr, we, wdata.
  - If WAIT_CYCLES > 0: go to WAIT with cnt = WAIT_CYCLES-1.
  - If WAIT_CYCLES = 0: go directly to RESP and commit on that same edge.
- WAIT:
  - cnt == 0: go to RESP and commit on this edge; otherwise decrement cnt.
  - Inputs are ignored in WAIT; only latched values are used.
  - req dropping during WAIT does not cancel the transaction.
- Commit, on the edge entering RESP:
  - Write: mem[addr_l] <= wdata_l; rdata is unchanged.
  - Read: rdata <= mem[addr_l].
  - ack <= 1 on the same edge.
- Latency: req sampled at edge k -> ack high in the cycle after edge k+WAIT_CYCLES (k for WAIT_CYCLES = 0).
- RESP:
  - ack <= 0 on the next edge.
  - Next state is IDLE if req = 0, else RELEASE.
- RELEASE:
  - Stay until req is sampled 0, then go to IDLE.
  - A held req never launches a second transaction; the requester must drop req for at least one edge between transactions.
- rdata holds its last value outside ack.
- Read-after-write to the same address returns the written value; there are no stale reads because writes commit before any later capture.
- busy = (state != IDLE).
- Address wrap: addr is exactly AW bits, so there is no out-of-range access.
- Reset mid-operation:
  - Reset in WAIT aborts the transaction; no write occurs and ack is never raised.
  - Reset in RESP/RELEASE clears everything, including the word just written.

Optional Feature:
- DMEM_ACCESS_CNT_EN defined:
  - Adds outputs rd_cnt[15:0] and wr_cnt[15:0].
  - Each counter increments on the commit edge of a read or write respectively.
  - Counters saturate at 16'hFFFF and reset to 0 on rst_n.
- Not defined: the ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Reset check: hold rst_n low, release -> ack = 0, busy = 0, rdata = 0; a read of each address 0..15 returns 16'h0000.
- Write then read, WAIT_CYCLES = 2:
  - Write 16'hBEEF to addr 4, req sampled at edge 1 -> ack high only in the cycle after edge 3.
  - Drop req, then read addr 4 -> rdata = 16'hBEEF with ack.
- WAIT_CYCLES = 0 build: read addr 4 after writing 16'h1234 -> ack in the cycle after the capture edge, rdata = 16'h1234.
- Held req: keep req = 1 for 10 cycles after ack -> exactly one ack pulse, busy stays high (RELEASE); drop req -> busy = 0 one edge later.
- Reset mid-WAIT: write 16'hAAAA to addr 7, pull rst_n low during WAIT -> no ack; a later read of addr 7 returns 16'h0000.
- With DMEM_ACCESS_CNT_EN: 3 writes and 2 reads -> wr_cnt = 3, rd_cnt = 2; preload both to saturation via 65535+ accesses (or a force) -> counter stays at 16'hFFFF.
